// File: rtl/apb_node_tmo.sv
// apb_node_tmo: registered APB 1-to-NB_MASTER node.
// Decodes each upstream transfer against inclusive per-port address ranges and replays it
// on the selected downstream port. Unmapped addresses and downstream PREADY timeouts are
// answered with PSLVERR, a one-cycle error pulse and the offending address.
module apb_node_tmo #(
    parameter int NB_MASTER      = 9,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
    input  logic                                pwrite_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    output logic [APB_DATA_WIDTH-1:0]           prdata_o,
    output logic                                pready_o,
    output logic                                pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic                                pwrite_o,
    output logic [NB_MASTER-1:0]                psel_o,
    output logic [NB_MASTER-1:0]                penable_o,
    input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                pready_i,
    input  logic [NB_MASTER-1:0]                pslverr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                err_unmap_o,
    output logic                                err_tmo_o,
    output logic [APB_ADDR_WIDTH-1:0]           err_addr_o
);

    localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DSETUP  = 3'd1;
    localparam logic [2:0] ST_DACCESS = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    logic [2:0]                state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      slverr_q;
    logic                      tmo_q;
    logic                      abort_q;
    logic [APB_ADDR_WIDTH-1:0] err_addr_q;

    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic [NB_MASTER-1:0]      sel_vec;
    logic                      sel_ready;
    logic                      sel_slverr;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      upstream_gone;

    // Address decode: lowest-index inclusive range containing paddr_i wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = 0; k < NB_MASTER; k++) begin
            if (!hit &&
                paddr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // One-hot port vector and response mux for the registered port index
    always_comb begin
        sel_vec    = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int unsigned k = 0; k < NB_MASTER; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_vec[k] = 1'b1;
                sel_ready  = pready_i[k];
                sel_slverr = pslverr_i[k];
                sel_rdata  = prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // A dropped upstream select means the downstream answer must be discarded
    assign upstream_gone = abort_q | ~psel_i;

    // Transfer FSM with captured request, response and error information
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
            tmo_q      <= 1'b0;
            abort_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        paddr_q  <= paddr_i;
                        pwdata_q <= pwdata_i;
                        pwrite_q <= pwrite_i;
                        abort_q  <= 1'b0;
                        tmo_q    <= 1'b0;
                        if (hit) begin
                            idx_q   <= hit_idx;
                            state_q <= ST_DSETUP;
                        end else begin
                            err_addr_q <= paddr_i;
                            state_q    <= ST_ERR;
                        end
                    end
                end
                ST_DSETUP: begin
                    cnt_q <= '0;
                    if (!psel_i) abort_q <= 1'b1;
                    state_q <= ST_DACCESS;
                end
                ST_DACCESS: begin
                    if (!psel_i) abort_q <= 1'b1;
                    if (sel_ready) begin
                        rdata_q  <= sel_rdata;
                        slverr_q <= sel_slverr;
                        state_q  <= upstream_gone ? ST_IDLE : ST_RESP;
                    end else if (TMO_EN && cnt_q == TMO_LAST) begin
                        if (upstream_gone) begin
                            state_q <= ST_IDLE;
                        end else begin
                            tmo_q      <= 1'b1;
                            err_addr_q <= paddr_q;
                            state_q    <= ST_ERR;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode: every output is derived from registered state only
    always_comb begin
        psel_o      = '0;
        penable_o   = '0;
        pready_o    = 1'b0;
        pslverr_o   = 1'b0;
        prdata_o    = '0;
        err_unmap_o = 1'b0;
        err_tmo_o   = 1'b0;
        case (state_q)
            ST_DSETUP: psel_o = sel_vec;
            ST_DACCESS: begin
                psel_o    = sel_vec;
                penable_o = sel_vec;
            end
            ST_RESP: begin
                pready_o  = 1'b1;
                pslverr_o = slverr_q;
                prdata_o  = rdata_q;
            end
            ST_ERR: begin
                pready_o    = 1'b1;
                pslverr_o   = 1'b1;
                err_unmap_o = ~tmo_q;
                err_tmo_o   = tmo_q;
            end
            default: ;
        endcase
    end

    assign paddr_o    = paddr_q;
    assign pwdata_o   = pwdata_q;
    assign pwrite_o   = pwrite_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_apb_node_tmo.sv
// tb_apb_node_tmo: randomized and directed checks of apb_node_tmo against a
// range-table reference model of decode, latency, timeout and error reporting.
module tb_apb_node_tmo;

    localparam int NB  = 9;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [AW-1:0]  paddr_i = '0;
    logic [DW-1:0]  pwdata_i = '0;
    logic           pwrite_i = 1'b0;
    logic           psel_i = 1'b0;
    logic           penable_i = 1'b0;
    logic [DW-1:0]  prdata_o;
    logic           pready_o;
    logic           pslverr_o;
    logic [AW-1:0]  paddr_o;
    logic [DW-1:0]  pwdata_o;
    logic           pwrite_o;
    logic [NB-1:0]  psel_o;
    logic [NB-1:0]  penable_o;
    logic [NB*DW-1:0] prdata_i = '0;
    logic [NB-1:0]  pready_i = '0;
    logic [NB-1:0]  pslverr_i = '0;
    logic [NB*AW-1:0] start_addr_i = '0;
    logic [NB*AW-1:0] end_addr_i = '0;
    logic           err_unmap_o;
    logic           err_tmo_o;
    logic [AW-1:0]  err_addr_o;

    apb_node_tmo #(
        .NB_MASTER     (NB),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .paddr_i     (paddr_i),
        .pwdata_i    (pwdata_i),
        .pwrite_i    (pwrite_i),
        .psel_i      (psel_i),
        .penable_i   (penable_i),
        .prdata_o    (prdata_o),
        .pready_o    (pready_o),
        .pslverr_o   (pslverr_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pwrite_o    (pwrite_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .start_addr_i(start_addr_i),
        .end_addr_i  (end_addr_i),
        .err_unmap_o (err_unmap_o),
        .err_tmo_o   (err_tmo_o),
        .err_addr_o  (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rs [NB];
    logic [31:0] re [NB];
    logic [31:0] last_err = '0;
    int          sl_waits = 0;
    int          sl_acc = 0;
    logic        sl_err = 1'b0;

    // Reference decode: first port whose inclusive range holds the address
    function automatic int model_port(input logic [31:0] a);
        for (int k = 0; k < NB; k++)
            if (a >= rs[k] && a <= re[k]) return k;
        return -1;
    endfunction

    // Reference latency from upstream SETUP to pready_o, in cycles
    function automatic int model_latency(input int idx, input int waits);
        if (idx < 0) return 1;
        if (waits >= TMO) return 2 + TMO;
        return 3 + waits;
    endfunction

    function automatic logic [NB-1:0] model_sel(input int idx);
        logic [NB-1:0] one;
        one = 1;
        return (idx < 0) ? '0 : (one << idx);
    endfunction

    // Downstream slave: answers the enabled port after sl_waits wait states
    task automatic slave_step();
        if (penable_o != '0) begin
            sl_acc++;
            pready_i  = (sl_acc - 1 == sl_waits) ? penable_o : '0;
            pslverr_i = sl_err ? penable_o : '0;
        end else begin
            pready_i  = '0;
            pslverr_i = '0;
        end
    endtask

    // One upstream transfer; returns what was observed (cycle indices relative to SETUP)
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                            input int waits, input logic [31:0] rd, input logic se,
                            output int rdy_c, output logic [31:0] prd, output logic perr,
                            output logic unmap, output logic tmo, output logic [NB-1:0] sel,
                            output int acc, output logic bus_ok, output logic stray);
        @(posedge clk_i);
        #1;
        paddr_i = a; pwdata_i = wd; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
        for (int k = 0; k < NB; k++) prdata_i[k*DW +: DW] = rd ^ 32'(k);
        sl_waits = waits; sl_acc = 0; sl_err = se;
        rdy_c = -1; prd = '0; perr = 1'b0; unmap = 1'b0; tmo = 1'b0;
        sel = '0; bus_ok = 1'b1; stray = 1'b0;
        for (int c = 0; c < 40 && rdy_c < 0; c++) begin
            @(negedge clk_i);
            if (c == 1) penable_i = 1'b1;
            if (psel_o != '0 && sel == '0) sel = psel_o;
            if (penable_o != '0 && penable_o !== psel_o) bus_ok = 1'b0;
            if (psel_o != '0 && (paddr_o !== a || pwrite_o !== wr || (wr && pwdata_o !== wd)))
                bus_ok = 1'b0;
            if (pready_o) begin
                rdy_c = c; prd = prdata_o; perr = pslverr_o;
                unmap = err_unmap_o; tmo = err_tmo_o;
                if (paddr_o !== a) bus_ok = 1'b0;
                pready_i = '0; pslverr_i = '0; psel_i = 1'b0; penable_i = 1'b0;
            end else begin
                if (err_unmap_o || err_tmo_o || pslverr_o || prdata_o != '0) stray = 1'b1;
                slave_step();
            end
        end
        acc = sl_acc;
        psel_i = 1'b0; penable_i = 1'b0; pready_i = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (psel_o !== '0 || penable_o !== '0) begin
            n_fail++; $display("FAIL reset_sel: psel_o=%h penable_o=%h, required 0/0", psel_o, penable_o);
        end
        n_checks++;
        if ({pready_o, pslverr_o, err_unmap_o, err_tmo_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: rdy/err/unmap/tmo=%b, required 0000",
                               {pready_o, pslverr_o, err_unmap_o, err_tmo_o});
        end
        n_checks++;
        if (prdata_o !== '0 || err_addr_o !== '0) begin
            n_fail++; $display("FAIL reset_data: prdata_o=%h err_addr_o=%h, required 0/0", prdata_o, err_addr_o);
        end
        n_checks++;
        if (paddr_o !== '0 || pwdata_o !== '0 || pwrite_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: paddr_o=%h pwdata_o=%h pwrite_o=%b, required 0",
                               paddr_o, pwdata_o, pwrite_o);
        end
        rst_ni = 1'b1;
        last_err = '0;
    endtask

    task automatic test_read();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        run_xfer(32'h1A10_1004, 32'h0, 1'b0, 0, 32'hCAFE_0000, 1'b0,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (sel !== 9'h002) begin n_fail++; $display("FAIL read_sel: psel_o=%h, required 002", sel); end
        n_checks++;
        if (rc != 3) begin n_fail++; $display("FAIL read_latency: pready at T%0d, required T3", rc); end
        n_checks++;
        if (prd !== 32'hCAFE_0001 || perr !== 1'b0) begin
            n_fail++; $display("FAIL read_data: prdata_o=%h pslverr_o=%b, required cafe0001/0", prd, perr);
        end
        n_checks++;
        if (um || tm || st || !ok) begin
            n_fail++; $display("FAIL read_clean: unmap=%b tmo=%b stray=%b bus_ok=%b, required 0/0/0/1", um, tm, st, ok);
        end
    endtask

    task automatic test_write_waits();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        run_xfer(32'h1A10_0008, 32'h55, 1'b1, 3, 32'h0, 1'b0,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (sel !== 9'h001 || acc != 4) begin
            n_fail++; $display("FAIL write_sel: psel_o=%h enable_cycles=%0d, required 001/4", sel, acc);
        end
        n_checks++;
        if (rc != 6 || perr !== 1'b0) begin
            n_fail++; $display("FAIL write_latency: pready at T%0d pslverr=%b, required T6/0", rc, perr);
        end
        n_checks++;
        if (!ok || pwdata_o !== 32'h55 || pwrite_o !== 1'b1) begin
            n_fail++; $display("FAIL write_bus: bus_ok=%b pwdata_o=%h pwrite_o=%b, required 1/55/1", ok, pwdata_o, pwrite_o);
        end
    endtask

    task automatic test_unmapped();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        run_xfer(32'h2000_0000, 32'h1234, 1'b1, 0, 32'hFFFF_FFFF, 1'b0,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        last_err = 32'h2000_0000;
        n_checks++;
        if (rc != 1 || perr !== 1'b1 || prd !== '0) begin
            n_fail++; $display("FAIL unmap_resp: pready at T%0d pslverr=%b prdata=%h, required T1/1/0", rc, perr, prd);
        end
        n_checks++;
        if (um !== 1'b1 || tm !== 1'b0) begin
            n_fail++; $display("FAIL unmap_pulse: unmap=%b tmo=%b, required 1/0", um, tm);
        end
        n_checks++;
        if (err_addr_o !== 32'h2000_0000 || sel !== '0) begin
            n_fail++; $display("FAIL unmap_addr: err_addr_o=%h psel_seen=%h, required 20000000/0", err_addr_o, sel);
        end
    endtask

    task automatic test_timeout();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        run_xfer(32'h1A10_4010, 32'h0, 1'b0, 100, 32'h0BAD_0000, 1'b0,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        last_err = 32'h1A10_4010;
        n_checks++;
        if (acc != TMO || rc != 2 + TMO) begin
            n_fail++; $display("FAIL tmo_timing: enable_cycles=%0d pready at T%0d, required %0d/T%0d", acc, rc, TMO, 2 + TMO);
        end
        n_checks++;
        if (perr !== 1'b1 || tm !== 1'b1 || um !== 1'b0 || prd !== '0) begin
            n_fail++; $display("FAIL tmo_resp: pslverr=%b tmo=%b unmap=%b prdata=%h, required 1/1/0/0", perr, tm, um, prd);
        end
        n_checks++;
        if (err_addr_o !== 32'h1A10_4010) begin
            n_fail++; $display("FAIL tmo_addr: err_addr_o=%h, required 1a104010", err_addr_o);
        end
        // last wait state still inside the window
        run_xfer(32'h1A10_4020, 32'h0, 1'b0, TMO - 1, 32'h0BAD_0000, 1'b0,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (rc != 2 + TMO || perr !== 1'b0 || tm !== 1'b0 || prd !== 32'h0BAD_0003) begin
            n_fail++; $display("FAIL tmo_edge: pready at T%0d pslverr=%b tmo=%b prdata=%h, required T%0d/0/0/0bad0003",
                               rc, perr, tm, prd, 2 + TMO);
        end
        n_checks++;
        if (err_addr_o !== 32'h1A10_4010) begin
            n_fail++; $display("FAIL tmo_hold: err_addr_o=%h, required 1a104010", err_addr_o);
        end
    endtask

    task automatic test_overlap();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        run_xfer(32'h1A10_3000, 32'h0, 1'b0, 0, 32'h0, 1'b1,
                 rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (sel !== 9'h004) begin n_fail++; $display("FAIL overlap_sel: psel_o=%h, required 004", sel); end
        n_checks++;
        if (perr !== 1'b1 || um !== 1'b0 || tm !== 1'b0 || rc != 3) begin
            n_fail++; $display("FAIL overlap_err: pslverr=%b unmap=%b tmo=%b T%0d, required 1/0/0/T3", perr, um, tm, rc);
        end
    endtask

    task automatic test_back_to_back();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        logic [31:0] addrs [3];
        int          exp_lat [3];
        addrs = '{32'h1A12_0000, 32'h3000_0000, 32'hFFFF_FFFF};
        exp_lat = '{4, 1, 3};
        for (int i = 0; i < 3; i++) begin
            run_xfer(addrs[i], 32'h0, 1'b0, (i == 0) ? 1 : 0, 32'h7700_0000, 1'b0,
                     rc, prd, perr, um, tm, sel, acc, ok, st);
            n_checks++;
            if (rc != exp_lat[i]) begin
                n_fail++; $display("FAIL b2b_latency[%0d]: pready at T%0d, required T%0d", i, rc, exp_lat[i]);
            end
        end
        last_err = 32'h3000_0000;
        n_checks++;
        if (prd !== 32'h7700_0008 || sel !== 9'h100) begin
            n_fail++; $display("FAIL b2b_last: prdata=%h psel=%h, required 77000008/100", prd, sel);
        end
    endtask

    task automatic test_abort();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        logic saw;
        @(posedge clk_i);
        #1;
        paddr_i = 32'h1A10_4004; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
        sl_waits = 2; sl_acc = 0; sl_err = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (c == 1) psel_i = 1'b0;
            if (pready_o || err_unmap_o || err_tmo_o) saw = 1'b1;
            slave_step();
        end
        pready_i = '0;
        n_checks++;
        if (saw || sl_acc != 3) begin
            n_fail++; $display("FAIL abort_discard: upstream_resp=%b enable_cycles=%0d, required 0/3", saw, sl_acc);
        end
        run_xfer(32'h1A10_4008, 32'h0, 1'b0, 0, 32'h0, 1'b0, rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (rc != 3 || sel !== 9'h008) begin
            n_fail++; $display("FAIL abort_recover: pready at T%0d psel=%h, required T3/008", rc, sel);
        end
    endtask

    task automatic test_async_reset();
        int rc, acc; logic [31:0] prd; logic perr, um, tm, ok, st; logic [NB-1:0] sel;
        logic got;
        @(posedge clk_i);
        #1;
        paddr_i = 32'h1A11_0040; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0; pready_i = '0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk_i);
            if (c == 1) penable_i = 1'b1;
            if (penable_o != '0) got = 1'b1;
        end
        n_checks++;
        if (!got || penable_o !== 9'h040) begin
            n_fail++; $display("FAIL arst_access: penable_o=%h, required 040", penable_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (psel_o !== '0 || penable_o !== '0 || pready_o !== 1'b0) begin
            n_fail++; $display("FAIL arst_drop: psel_o=%h penable_o=%h pready_o=%b, required 0", psel_o, penable_o, pready_o);
        end
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        last_err = '0;
        n_checks++;
        if (err_addr_o !== '0) begin n_fail++; $display("FAIL arst_erraddr: err_addr_o=%h, required 0", err_addr_o); end
        run_xfer(32'h1A11_0040, 32'h0, 1'b0, 1, 32'h5A5A_0000, 1'b0, rc, prd, perr, um, tm, sel, acc, ok, st);
        n_checks++;
        if (rc != 4 || sel !== 9'h040 || prd !== 32'h5A5A_0006 || perr !== 1'b0) begin
            n_fail++; $display("FAIL arst_after: T%0d psel=%h prdata=%h pslverr=%b, required T4/040/5a5a0006/0", rc, sel, prd, perr);
        end
    endtask

    task automatic test_random();
        int rc, acc, k, mode, waits, idx, e_lat, e_acc;
        logic [31:0] a, wd, rd, prd, e_prd;
        logic wr, se, perr, um, tm, ok, st, e_tmo, e_errr, e_perr;
        logic [NB-1:0] sel;
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, NB - 1);
            mode = $urandom_range(0, 5);
            case (mode)
                0: a = rs[k];
                1: a = re[k];
                2: a = rs[k] - 1;
                3: a = re[k] + 1;
                4: a = (rs[k] <= re[k]) ? rs[k] + ($urandom % (re[k] - rs[k] + 1)) : $urandom;
                default: a = $urandom;
            endcase
            waits = $urandom_range(0, TMO + 1);
            wr = 1'($urandom_range(0, 1)); wd = $urandom; rd = $urandom;
            se = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) @(negedge clk_i);
            run_xfer(a, wd, wr, waits, rd, se, rc, prd, perr, um, tm, sel, acc, ok, st);

            idx    = model_port(a);
            e_tmo  = (idx >= 0) && (waits >= TMO);
            e_errr = (idx < 0) || e_tmo;
            e_lat  = model_latency(idx, waits);
            e_acc  = (idx < 0) ? 0 : (e_tmo ? TMO : waits + 1);
            e_prd  = e_errr ? 32'h0 : (rd ^ 32'(idx));
            e_perr = e_errr ? 1'b1 : se;
            if (e_errr) last_err = a;

            n_checks++;
            if (rc != e_lat) begin n_fail++; $display("FAIL rnd_latency it=%0d addr=%h: T%0d, required T%0d", it, a, rc, e_lat); end
            n_checks++;
            if (sel !== model_sel(idx)) begin n_fail++; $display("FAIL rnd_sel it=%0d addr=%h: %h, required %h", it, a, sel, model_sel(idx)); end
            n_checks++;
            if (acc != e_acc) begin n_fail++; $display("FAIL rnd_access it=%0d: %0d enable cycles, required %0d", it, acc, e_acc); end
            n_checks++;
            if (prd !== e_prd || perr !== e_perr) begin
                n_fail++; $display("FAIL rnd_resp it=%0d: prdata=%h pslverr=%b, required %h/%b", it, prd, perr, e_prd, e_perr);
            end
            n_checks++;
            if (um !== (idx < 0) || tm !== e_tmo) begin
                n_fail++; $display("FAIL rnd_pulse it=%0d: unmap=%b tmo=%b, required %b/%b", it, um, tm, idx < 0, e_tmo);
            end
            n_checks++;
            if (err_addr_o !== last_err) begin n_fail++; $display("FAIL rnd_erraddr it=%0d: %h, required %h", it, err_addr_o, last_err); end
            n_checks++;
            if (!ok || st) begin n_fail++; $display("FAIL rnd_bus it=%0d: bus_ok=%b stray=%b, required 1/0", it, ok, st); end
        end
    endtask

    initial begin
        rs = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_2000, 32'h1A10_4000, 32'h1A10_6000,
               32'h1A10_3000, 32'h1A11_0000, 32'h1A12_0000, 32'hF000_0000};
        re = '{32'h1A10_0FFF, 32'h1A10_1FFF, 32'h1A10_3FFF, 32'h1A10_4FFF, 32'h1A10_5000,
               32'h1A10_3FFF, 32'h1A11_FFFF, 32'h1A12_0000, 32'hFFFF_FFFF};
        for (int k = 0; k < NB; k++) begin
            start_addr_i[k*AW +: AW] = rs[k];
            end_addr_i[k*AW +: AW]   = re[k];
        end
        test_reset();
        test_read();
        test_write_waits();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
